// File: rtl/uart_angle_frame_rx.sv
// 8N1 UART receiver with a SYNC/hi/lo/checksum angle-frame parser.
// Optional inter-byte timeout is compiled in when RX_TIMEOUT_EN is defined.
module uart_angle_frame_rx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] angle,
  output logic        angle_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_HI, P_LO, P_CHK} parse_state_t;

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  parse_state_t     parse_state;
  logic [7:0]       hi_byte;
  logic [7:0]       lo_byte;
  logic             start_det;
  logic             stop_sample;
  logic             byte_done;
  logic             stop_err;
  logic             timeout;

  function automatic logic checksum_ok(input logic [7:0] hi, input logic [7:0] lo,
                                       input logic [7:0] chk);
    return chk == (SYNC_BYTE ^ hi ^ lo);
  endfunction

  // Input synchroniser: idles high so reset never looks like a start bit
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign start_det   = (rx_state == RX_IDLE) && !rx_sync;
  assign stop_sample = (rx_state == RX_STOP) && (bit_cnt == BIT_LAST);
  assign byte_done   = stop_sample && rx_sync;
  assign stop_err    = stop_sample && !rx_sync;

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_busy  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            if (!rx_sync) begin
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
              rx_busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          bit_cnt  <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if ((rx_state == RX_DATA) && (bit_cnt == BIT_LAST))
      shift_reg <= {rx_sync, shift_reg[7:1]};
  end

`ifdef RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] idle_cnt;

  assign timeout = (parse_state != P_HUNT) && (rx_state == RX_IDLE) && rx_sync &&
                   (idle_cnt == TO_W'(TO_LIMIT - 1));

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((parse_state == P_HUNT) || start_det || timeout) begin
      idle_cnt <= '0;
    end else if (rx_state == RX_IDLE) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame parser: acts on the stop-sample cycle so strobes land one cycle later
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      parse_state <= P_HUNT;
      angle       <= '0;
      angle_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (stop_err || timeout) begin
        frame_err   <= 1'b1;
        parse_state <= P_HUNT;
      end else if (byte_done) begin
        case (parse_state)
          P_HUNT: if (shift_reg == SYNC_BYTE) parse_state <= P_HI;
          P_HI:   parse_state <= P_LO;
          P_LO:   parse_state <= P_CHK;
          P_CHK: begin
            parse_state <= P_HUNT;
            if (checksum_ok(hi_byte, lo_byte, shift_reg)) begin
              angle       <= {hi_byte, lo_byte};
              angle_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: parse_state <= P_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (byte_done && (parse_state == P_HI)) hi_byte <= shift_reg;
    if (byte_done && (parse_state == P_LO)) lo_byte <= shift_reg;
  end

endmodule

// File: tb/tb_uart_angle_frame_rx.sv
// Bench for uart_angle_frame_rx: directed frames plus randomized frames
// checked against a byte-queue frame model; timeout case under RX_TIMEOUT_EN.
module tb_uart_angle_frame_rx;

  localparam int         CPB  = 16;
  localparam int         HALF = CPB / 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] angle;
  logic        angle_valid;
  logic        frame_err;
  logic        rx_busy;

  always #5 clk = ~clk;

  uart_angle_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk_50m    (clk),
    .rst        (rst),
    .rx         (rx),
    .angle      (angle),
    .angle_valid(angle_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  int checks = 0;
  int passes = 0;

  // Pulse monitor
  int          vcnt = 0;
  int          ecnt = 0;
  int          overlap = 0;
  int          wide = 0;
  logic        prev_v = 1'b0;
  logic        prev_e = 1'b0;
  logic [15:0] pulse_angle = '0;

  always @(negedge clk) begin
    if (angle_valid) begin
      vcnt        <= vcnt + 1;
      pulse_angle <= angle;
    end
    if (frame_err) ecnt <= ecnt + 1;
    if (angle_valid && frame_err) overlap <= overlap + 1;
    if ((angle_valid && prev_v) || (frame_err && prev_e)) wide <= wide + 1;
    prev_v <= angle_valid;
    prev_e <= frame_err;
  end

  // Frame-level reference model
  logic [7:0]  q[$];
  logic [15:0] m_angle = '0;
  int          m_valid = 0;
  int          m_err = 0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_err++;
      q.delete();
      return;
    end
    if (q.size() == 0 && b != SYNC) return;
    q.push_back(b);
    if (q.size() == 4) begin
      if ((q[0] ^ q[1] ^ q[2]) == q[3]) begin
        m_angle = {q[1], q[2]};
        m_valid++;
      end else begin
        m_err++;
      end
      q.delete();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Caller must be at a negedge; consecutive calls are truly back-to-back
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic check_all(input string tag);
    idle(4);
    check({tag, "_angle"}, {16'h0, angle}, {16'h0, m_angle});
    check({tag, "_valid_cnt"}, vcnt, m_valid);
    check({tag, "_err_cnt"}, ecnt, m_err);
  endtask

  initial begin
    int          mode;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  ck;
    logic [7:0]  g;
    int          waited;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_angle", {16'h0, angle}, 32'h0);
    check("reset_valid", {31'h0, angle_valid}, 32'h0);
    check("reset_err", {31'h0, frame_err}, 32'h0);
    check("reset_busy", {31'h0, rx_busy}, 32'h0);
    rst = 1'b1;
    idle(5);

    send_frame(8'hA5, 8'h12, 8'h34, 8'h83);
    check_all("good_1234");
    check("pulse_angle", {16'h0, pulse_angle}, 32'h1234);

    send_frame(8'hA5, 8'h12, 8'h34, 8'h00);
    check_all("bad_chk");

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_frame(8'hA5, 8'h00, 8'h10, 8'hB5);
    check_all("garbage_then_0010");

    // Short low pulse on rx: must be rejected as a glitch
    check("busy_idle", {31'h0, rx_busy}, 32'h0);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_rise", {31'h0, rx_busy}, 32'h1);
    repeat (1) @(negedge clk);
    rx = 1'b1;
    waited = 0;
    while (rx_busy === 1'b1 && waited < HALF + 3) begin
      @(negedge clk);
      waited++;
    end
    check("busy_fall_bounded", {31'h0, rx_busy}, 32'h0);
    check_all("glitch");

    send_byte(8'hA5, 1'b0);
    send_frame(8'hA5, 8'hAB, 8'hCD, 8'hC3);
    check_all("stop_err_then_abcd");

    // Reset in the middle of a frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    q.delete();
    m_angle = '0;
    idle(2);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_angle", {16'h0, angle}, 32'h0);
    check("midreset_busy", {31'h0, rx_busy}, 32'h0);
    rst = 1'b1;
    idle(3);
    check("midreset_valid_cnt", vcnt, m_valid);
    check("midreset_err_cnt", ecnt, m_err);
    send_frame(8'hA5, 8'h00, 8'h01, 8'hA4);
    check_all("after_reset_0001");

`ifdef RX_TIMEOUT_EN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    idle(25 * CPB);
    m_err++;
    q.delete();
    check_all("timeout");
    send_frame(8'hA5, 8'h00, 8'h01, 8'hA4);
    check_all("after_timeout");
`endif

    for (int it = 0; it < 20; it++) begin
      mode = int'($urandom_range(0, 3));
      hi   = 8'($urandom);
      lo   = 8'($urandom);
      ck   = SYNC ^ hi ^ lo;
      case (mode)
        1: ck = ck ^ (8'h01 << $urandom_range(0, 7));
        2: begin
          g = 8'($urandom);
          send_byte(g, 1'b1);
        end
        3: send_byte(8'($urandom), 1'b0);
        default: ;
      endcase
      send_frame(SYNC, hi, lo, ck);
      check_all("random");
    end

    idle(4);
    check("no_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_angle_frame_rx.md
# uart_angle_frame_rx

Receive-side counterpart of the angle UART link: deserialises 8N1 bytes arriving on `rx` from the ESP32 and parses fixed 4-byte angle frames into a 16-bit angle with a one-cycle valid strobe. Sits beside the UART transmit path in `simp`, on the `rx` pin. Used for host-commanded setpoints and for loopback checking of transmitted angles.

## Interface
- `CLKS_PER_BIT`, 434, `clk_50m` cycles per UART bit (50 MHz / 115200).
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_BITS`, 20, inter-byte timeout in bit periods; used only when `RX_TIMEOUT_EN` is defined.
- `clk_50m`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, idle high, asynchronous to `clk_50m`.
- `angle`  out  16  last accepted angle, held between frames.
- `angle_valid`  out  1  one-cycle pulse when `angle` updates.
- `frame_err`  out  1  one-cycle pulse on checksum, stop-bit or timeout error.
- `rx_busy`  out  1  high while a byte is being deserialised (start detected → stop sampled).

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE: synchronised `rx` = 0 → START, counter cleared.
  - START: after `CLKS_PER_BIT/2` (217) cycles, sample. 0 → DATA. 1 → IDLE (glitch, no byte, no error).
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, shift into byte register.
  - STOP: sample after `CLKS_PER_BIT` cycles. 1 → internal `byte_done` pulse. 0 → `frame_err` pulse, byte discarded, parser forced to HUNT. Either way, return to IDLE at the mid-stop sample, so back-to-back bytes are accepted.
- Frame parser states: HUNT, HI, LO, CHK. Frame format: `SYNC_BYTE`, angle[15:8], angle[7:0], checksum.
  - HUNT: byte == `SYNC_BYTE` → HI. Any other byte is ignored silently.
  - HI: store hi byte → LO.
  - LO: store lo byte → CHK.
  - CHK: checksum must equal `SYNC_BYTE ^ hi ^ lo`. Match → `angle <= {hi,lo}`, `angle_valid` pulse. Mismatch → `frame_err` pulse, `angle` unchanged. Both cases → HUNT.
- A sync value received in HI/LO/CHK is treated as data, with no resynchronisation.
- `angle_valid` and `frame_err` never assert in the same cycle.

## Timing
- Reset values: `angle` = 0, `angle_valid` = 0, `frame_err` = 0, `rx_busy` = 0. Receiver in IDLE, parser in HUNT, counters 0.
- Reset mid-frame: the partial frame is discarded and no pulse is emitted. After release, the first valid sync restarts parsing.
- Start-bit mid-sample occurs 2 (sync) + 217 cycles after the pin falling edge. Data bit n is sampled 434·(n+1) cycles later. The stop bit is sampled 9·434 cycles after the start mid-sample.
- `angle_valid`/`frame_err` assert exactly 1 cycle after the checksum byte's stop sample (registered). Pulse width is 1 cycle.
- `rx_busy` rises the cycle after the falling edge is seen in IDLE. It falls the cycle after the stop sample or glitch rejection.
- Bit counter range is 0..`CLKS_PER_BIT`-1, with a width of ceil(log2(`CLKS_PER_BIT`)). No wrap occurs beyond the terminal count.

## Configuration
- `RX_TIMEOUT_EN` defined: while the parser is in HI, LO or CHK, a counter runs in IDLE between bytes. Reaching `TIMEOUT_BITS`·`CLKS_PER_BIT` cycles with no start bit gives a `frame_err` pulse and returns the parser to HUNT. The counter clears on each start detect.
- Not defined: no timeout logic is compiled. The parser waits indefinitely for the remaining frame bytes.

## Test plan
- Send A5 12 34 83 at 115200 → `angle` = 16'h1234 with one `angle_valid` pulse. `frame_err` stays 0.
- Send A5 12 34 00 → one `frame_err` pulse. `angle` keeps its prior value and there is no `angle_valid`.
- Send 00 FF A5 00 10 B5 back-to-back → garbage is ignored. `angle` = 16'h0010 with a single `angle_valid`.
- Drive `rx` low for 100 cycles then high → no byte, no pulses, and `rx_busy` returns to 0 within 219 cycles.
- Send A5 with stop bit forced 0, then A5 AB CD C3 → one `frame_err` on the first byte, then `angle` = 16'hABCD.
- Assert `rst` after A5 12, release, then send A5 00 01 A4 → no pulses before reset release, then `angle` = 16'h0001. With `RX_TIMEOUT_EN`: A5 12 followed by 25 idle bit times → one `frame_err`, and the parser is back in HUNT.
